cpuclk_gen: RTL and testbench

Parametrised, fully synchronous successor to the fixed single-output CPU clock wrapper. It produces NUM_CH independent divided clock-enable pulses and matching divided square-wave outputs from one fabric clock. Each channel's divide ratio is programmable at run time and changes without runt pulses. It adds a startup lock indication and a global phase-realign input. It sits at the top of the CPU core and feeds the CPU, memory and peripheral clock domains.

---
 rtl/cpuclk_gen.sv | 116 +++++++++++
 tb/tb_cpuclk_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpuclk_gen.sv
// Multi-channel CPU clock-enable generator with runtime-programmable divide ratios,
// glitch-free ratio changes, a startup lock delay and a global phase realign.
module cpuclk_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DIV_INIT    = 4,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] pending,
    output logic              locked
);

    localparam int               LK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

    logic [LK_W-1:0] lock_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            lock_cnt <= lock_cnt + LK_W'(1);
            if (lock_cnt == LK_W'(LOCK_CYCLES - 1)) begin
                locked <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt, cnt_n, div_act, div_pend, new_act, half;
        logic             pend, wr_hit, wrap, apply, ce_n, clk_n, ce_q, clk_q;

        // Out-of-range channel numbers never match any g, so such writes are dropped.
        assign wr_hit = div_wr && (div_ch == CH_W'(g));

        always_comb begin
            // NOTE: every variable gets a default before any branch, so no latch can be inferred.
            wrap  = 1'b0;
            apply = 1'b0;
            cnt_n = '0;
            ce_n  = 1'b0;
            clk_n = 1'b0;

            if (locked && !sync && div_act != '0) begin
                wrap = (cnt == div_act - CNT_W'(1));
            end

            // Idle, unlocked or realigning channels have no period in flight to protect.
            if (!locked || sync || div_act == '0) begin
                apply = pend;
            end else begin
                apply = pend && wrap;
            end

            new_act = apply ? div_pend : div_act;
            half    = new_act >> 1;

            if (locked && !sync && div_act != '0 && !wrap) begin
                cnt_n = cnt + CNT_W'(1);
            end

            if (!locked) begin
                ce_n  = 1'b0;
                clk_n = 1'b0;
            end else if (sync) begin
                clk_n = (half != '0);
            end else if (div_act == '0) begin
                // A ratio landing on a disabled channel starts a fresh period at once.
                ce_n  = (new_act != '0);
                clk_n = (half != '0);
            end else begin
                ce_n  = wrap;
                clk_n = (cnt_n < half);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= '0;
                div_act  <= DIV_RST;
                div_pend <= DIV_RST;
                pend     <= 1'b0;
                ce_q     <= 1'b0;
                clk_q    <= 1'b0;
            end else begin
                cnt     <= cnt_n;
                div_act <= new_act;
                ce_q    <= ce_n;
                clk_q   <= clk_n;
                if (wr_hit) begin
                    div_pend <= div_val;
                    pend     <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign ce_out[g]  = ce_q;
        assign clk_div[g] = clk_q;
        assign pending[g] = pend;
    end

endmodule

// File: tb/tb_cpuclk_gen.sv
// Directed bench for cpuclk_gen: lock delay, ratio staging/apply, disable, sync, reset.
module tb_cpuclk_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_wr;
    logic [0:0]  div_ch;
    logic [15:0] div_val;
    logic        sync;
    logic [1:0]  ce_out, clk_div, pending;
    logic        locked;

    // Three-channel instance, used where an out-of-range channel number is encodable.
    logic        wr3;
    logic [1:0]  ch3;
    logic [15:0] val3;
    logic        sync3;
    logic [2:0]  ce3, clkd3, pend3;
    logic        lock3;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    cpuclk_gen u_dut (
        .clk(clk), .rst_n(rst_n), .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .sync(sync), .ce_out(ce_out), .clk_div(clk_div), .pending(pending), .locked(locked)
    );

    cpuclk_gen #(.NUM_CH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .div_wr(wr3), .div_ch(ch3), .div_val(val3),
        .sync(sync3), .ce_out(ce3), .clk_div(clkd3), .pending(pend3), .locked(lock3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        edge_n++;
    endtask

    task automatic go_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic write(input logic [0:0] ch, input logic [15:0] v);
        div_wr  = 1'b1;
        div_ch  = ch;
        div_val = v;
        step();
        div_wr  = 1'b0;
    endtask

    task automatic lock_seq(input string pfx);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("%s_lock_e%0d", pfx, k), 32'(locked), (k == 16) ? 1 : 0);
        end
        check($sformatf("%s_ce_at_lock", pfx), 32'(ce_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0; sync = 1'b0;
        wr3 = 1'b0; ch3 = '0; val3 = '0; sync3 = 1'b0;
        #1;
        check("rst_locked",  32'(locked),  0);
        check("rst_ce",      32'(ce_out),  0);
        check("rst_clkdiv",  32'(clk_div), 0);
        check("rst_pending", 32'(pending), 0);

        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        lock_seq("start");

        // Default ratio 4 on both channels: pulse every 4, clk_div 1,1,0,0.
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("def_ce_%0d", j),  32'(ce_out),  (j % 4 == 0) ? 3 : 0);
            check($sformatf("def_clk_%0d", j), 32'(clk_div), (j % 4 < 2) ? 3 : 0);
        end

        // Ratio 6 written to ch1 mid-period; current 4-cycle period completes first.
        go_to(29);
        write(1'b1, 16'd6);
        check("r6_pend_30", 32'(pending), 2);
        step();
        check("r6_pend_31", 32'(pending), 2);
        check("r6_ce_31",   32'(ce_out),  0);
        step();
        check("r6_ce_32",   32'(ce_out),  3);
        check("r6_pend_32", 32'(pending), 0);
        check("r6_clk_32",  32'(clk_div), 3);
        for (int e = 33; e <= 44; e++) begin
            int d;
            step();
            d = e - 32;
            check($sformatf("r6_ce_%0d", e),  32'(ce_out),
                  ((d % 4 == 0) ? 1 : 0) | ((d % 6 == 0) ? 2 : 0));
            check($sformatf("r6_clk_%0d", e), 32'(clk_div),
                  ((d % 4 < 2) ? 1 : 0) | ((d % 6 < 3) ? 2 : 0));
        end

        // Disable ch0; meanwhile an out-of-range write on the 3-channel instance.
        write(1'b0, 16'd0);
        check("dis_pend_45", 32'(pending), 1);
        wr3 = 1'b1; ch3 = 2'd3; val3 = 16'd9;
        step();
        wr3 = 1'b0;
        check("oor_pend_46", 32'(pend3), 0);
        step();
        check("oor_ce_47", 32'(ce3), 0);
        step();
        check("oor_ce_48",   32'(ce3),        7);
        check("dis_ce_48",   32'(ce_out[0]),  1);
        check("dis_pend_48", 32'(pending[0]), 0);
        for (int e = 49; e <= 52; e++) begin
            step();
            check($sformatf("dis_ce_%0d", e),  32'(ce_out[0]),  0);
            check($sformatf("dis_clk_%0d", e), 32'(clk_div[0]), 0);
        end

        // Ratio 1 on a disabled channel: ce constantly high, clk_div constantly low.
        write(1'b0, 16'd1);
        check("r1_pend_53", 32'(pending[0]), 1);
        check("r1_ce_53",   32'(ce_out[0]),  0);
        for (int e = 54; e <= 58; e++) begin
            step();
            check($sformatf("r1_ce_%0d", e),  32'(ce_out[0]),  1);
            check($sformatf("r1_clk_%0d", e), 32'(clk_div[0]), 0);
        end

        // Back to 4, then 7 overwritten by 3 inside one period: only 3 is applied.
        write(1'b0, 16'd4);
        step();
        check("r4_ce_60",   32'(ce_out[0]),  1);
        check("r4_pend_60", 32'(pending[0]), 0);
        write(1'b0, 16'd7);
        write(1'b0, 16'd3);
        step();
        check("ow_ce_63", 32'(ce_out[0]), 0);
        step();
        check("ow_ce_64",   32'(ce_out[0]),  1);
        check("ow_pend_64", 32'(pending[0]), 0);
        for (int e = 65; e <= 70; e++) begin
            step();
            check($sformatf("ow_ce_%0d", e),  32'(ce_out[0]),  ((e - 64) % 3 == 0) ? 1 : 0);
            check($sformatf("ow_clk_%0d", e), 32'(clk_div[0]), ((e - 64) % 3 == 0) ? 1 : 0);
        end

        // Write landing on the apply edge: staged 2 applies, new 5 stays pending.
        write(1'b0, 16'd2);
        step();
        write(1'b0, 16'd5);
        check("wa_pend_73", 32'(pending[0]), 1);
        check("wa_ce_73",   32'(ce_out[0]),  1);
        check("wa_clk_73",  32'(clk_div[0]), 1);
        step();
        check("wa_ce_74",  32'(ce_out[0]),  0);
        check("wa_clk_74", 32'(clk_div[0]), 0);
        step();
        check("wa_ce_75",   32'(ce_out[0]),  1);
        check("wa_pend_75", 32'(pending[0]), 0);
        check("wa_clk_75",  32'(clk_div[0]), 1);
        go_to(79);
        check("wa_ce_79", 32'(ce_out[0]), 0);
        step();
        check("wa_ce_80", 32'(ce_out[0]), 1);

        // ch0 back to 4 (ch1 is 6), then sync realigns both.
        write(1'b0, 16'd4);
        go_to(85);
        check("pre_sync_ce_85",   32'(ce_out),  1);
        check("pre_sync_pend_85", 32'(pending), 0);
        go_to(87);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_ce_88",  32'(ce_out),  0);
        check("sync_clk_88", 32'(clk_div), 3);
        for (int e = 89; e <= 112; e++) begin
            int d;
            step();
            d = e - 88;
            check($sformatf("sync_ce_%0d", e),  32'(ce_out),
                  ((d % 4 == 0) ? 1 : 0) | ((d % 6 == 0) ? 2 : 0));
            check($sformatf("sync_clk_%0d", e), 32'(clk_div),
                  ((d % 4 < 2) ? 1 : 0) | ((d % 6 < 3) ? 2 : 0));
        end

        // One-cycle reset mid-period: outputs clear at once, lock restarts, ratios return to 4.
        go_to(114);
        rst_n = 1'b0;
        #1;
        check("mrst_locked",  32'(locked),  0);
        check("mrst_ce",      32'(ce_out),  0);
        check("mrst_clkdiv",  32'(clk_div), 0);
        check("mrst_pending", 32'(pending), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        lock_seq("relock");
        for (int j = 1; j <= 8; j++) begin
            step();
            check($sformatf("relock_ce_%0d", j), 32'(ce_out), (j % 4 == 0) ? 3 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
